// File: rtl/rtc_bus_master_if.sv
// Host-side handshake bundle for rtc_bus_master: request fields in, status and
// read data out. burst_len exists only when RTC_BURST_EN is defined.
`timescale 1ns/1ps
interface rtc_bus_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef RTC_BURST_EN
  logic [3:0]        burst_len;
`endif
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              busy;
  logic              done;

`ifdef RTC_BURST_EN
  modport master (output req, rw, addr, wdata, burst_len, input rdata, rd_valid, busy, done);
  modport slave  (input req, rw, addr, wdata, burst_len, output rdata, rd_valid, busy, done);
`else
  modport master (output req, rw, addr, wdata, input rdata, rd_valid, busy, done);
  modport slave  (input req, rw, addr, wdata, output rdata, rd_valid, busy, done);
`endif
endinterface

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: master for multiplexed address/data RTC chips with active-low
// CS/WR/RD/AD strobes, programmable phase/gap timing and a free-running clk_out.
// Define RTC_BURST_EN to add multi-beat reads (burst_len on the host interface).
//
// state | meaning
// IDLE  | waiting for req, bus released
// A_ACT | address strobe: CS/AD/WR low, bus drives address
// A_REL | strobes released, address still held on bus
// D_ACT | data strobe: WR low (write, bus drives wdata) or RD low (read, bus released)
// D_REL | strobes released, write data held / read bus released
// GAP   | bus turnaround before the next request
`timescale 1ns/1ps
module rtc_bus_master #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int T_PH    = 4,
  parameter int T_GAP   = 2,
  parameter int CLK_DIV = 50
) (
  input  logic              clk,
  input  logic              clr,
  rtc_bus_master_if.slave   host,
  output logic              CS,
  output logic              WR,
  output logic              RD,
  output logic              AD,
  output logic              clk_out,
  inout  wire  [DATA_W-1:0] dato_rtc
);
  localparam int CNT_MAX = (T_PH > T_GAP) ? T_PH : T_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] PH_LD  = CNT_W'(T_PH - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((T_GAP > 0) ? T_GAP - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_LD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, A_ACT, A_REL, D_ACT, D_REL, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        beats, beats_nxt, burst_ld;
  logic              rw_q, rw_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] bus_q, bus_nxt;
  logic              drive_q, drive_nxt;
  logic              cs_nxt, wr_nxt, rd_nxt, ad_nxt;
  logic              sample;
  logic [DIV_W-1:0]  div_cnt;

`ifdef RTC_BURST_EN
  assign burst_ld = host.rw ? host.burst_len : 4'd0;
`else
  assign burst_ld = 4'd0;
`endif

  // Read data is valid on the edge that ends the last D_ACT cycle.
  assign sample   = (state == D_ACT) && (cnt == '0) && rw_q;
  assign dato_rtc = drive_q ? bus_q : {DATA_W{1'bz}};

  // Sequencer: phase timer counts down to zero, burst beats re-enter A_ACT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    beats_nxt = beats;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: if (host.req) begin
        state_nxt = A_ACT;
        cnt_nxt   = PH_LD;
        beats_nxt = burst_ld;
        rw_nxt    = host.rw;
        addr_nxt  = host.addr;
        wdata_nxt = host.wdata;
      end
      A_ACT: if (cnt == '0) state_nxt = A_REL; else cnt_nxt = cnt - CNT_W'(1);
      A_REL: begin
        state_nxt = D_ACT;
        cnt_nxt   = PH_LD;
      end
      D_ACT: if (cnt == '0) state_nxt = D_REL; else cnt_nxt = cnt - CNT_W'(1);
      D_REL:
        if (rw_q && beats != 4'd0) begin
          state_nxt = A_ACT;
          cnt_nxt   = PH_LD;
          beats_nxt = beats - 4'd1;
          addr_nxt  = addr_q + ADDR_W'(1);
        end else if (T_GAP == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end
      GAP: if (cnt == '0) state_nxt = IDLE; else cnt_nxt = cnt - CNT_W'(1);
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe and bus values for the next state, so the pins come straight from flops.
  always_comb begin
    cs_nxt    = !(state_nxt == A_ACT || state_nxt == D_ACT);
    ad_nxt    = (state_nxt != A_ACT);
    wr_nxt    = !(state_nxt == A_ACT || (state_nxt == D_ACT && !rw_nxt));
    rd_nxt    = !(state_nxt == D_ACT && rw_nxt);
    drive_nxt = 1'b0;
    bus_nxt   = '0;
    if (state_nxt == A_ACT || state_nxt == A_REL) begin
      drive_nxt = 1'b1;
      bus_nxt   = DATA_W'(addr_nxt);
    end else if ((state_nxt == D_ACT || state_nxt == D_REL) && !rw_nxt) begin
      drive_nxt = 1'b1;
      bus_nxt   = wdata_nxt;
    end
  end

  // State, timer and latched request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      beats   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      beats   <= beats_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  // Registered pins: strobes and bus drive.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      CS      <= 1'b1;
      WR      <= 1'b1;
      RD      <= 1'b1;
      AD      <= 1'b1;
      drive_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      CS      <= cs_nxt;
      WR      <= wr_nxt;
      RD      <= rd_nxt;
      AD      <= ad_nxt;
      drive_q <= drive_nxt;
      bus_q   <= bus_nxt;
    end
  end

  // Host status and read capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      host.rd_valid <= 1'b0;
      host.rdata    <= '0;
    end else begin
      host.busy     <= (state_nxt != IDLE);
      host.done     <= (state != IDLE) && (state_nxt == IDLE);
      host.rd_valid <= sample;
      if (sample) host.rdata <= dato_rtc;
    end
  end

  // Free-running divider for the RTC clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_cnt <= DIV_LD;
      clk_out <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LD;
      clk_out <= ~clk_out;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end
endmodule

// File: tb/tb_rtc_bus_master.sv
// Bench for rtc_bus_master: a simple RTC chip model answers reads, and each
// transaction is checked cycle by cycle against a phase schedule derived from
// T_PH/T_GAP arithmetic. A pull-up makes a released bus read as all ones.
`timescale 1ns/1ps
module tb_rtc_bus_master;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int T_PH    = 4;
  localparam int T_GAP   = 2;
  localparam int CLK_DIV = 50;
  localparam int BEAT    = 2 * T_PH + 2;
`ifdef RTC_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  logic CS, WR, RD, AD, clk_out;
  wire  [DATA_W-1:0] dato_rtc;

  rtc_bus_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  rtc_bus_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .T_PH(T_PH), .T_GAP(T_GAP), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .clr(clr), .host(bus_if),
    .CS(CS), .WR(WR), .RD(RD), .AD(AD), .clk_out(clk_out), .dato_rtc(dato_rtc)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup (dato_rtc[i]);
  end

  // RTC chip model: latches the address while AD is low, drives its register while RD is low.
  logic [DATA_W-1:0] chip_mem [256];
  logic [7:0]        rtc_addr;
  always @(posedge clk) if (!AD && !CS) rtc_addr <= dato_rtc;
  assign dato_rtc = (!RD && !CS) ? chip_mem[rtc_addr] : {DATA_W{1'bz}};

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] last_rdata;

  // One transaction: request, then every busy cycle plus the done cycle against the schedule.
  task automatic do_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        input int blen, input bit hold_req, input string tag);
    int beats, len, beat, off, ph;
    logic [7:0] a, exp_bus;
    logic [3:0] exp_str;
    logic [2:0] exp_st;
    logic exp_rv;
    beats = (rw && BURST) ? blen + 1 : 1;
    len   = beats * BEAT + T_GAP;
    for (int w = 0; w < 400 && bus_if.busy !== 1'b0; w++) @(negedge clk);
    n_checks++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_wait: busy=%b required 0", tag, bus_if.busy);
    end
    bus_if.req   = 1'b1;
    bus_if.rw    = rw;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
`ifdef RTC_BURST_EN
    bus_if.burst_len = 4'(blen);
`endif
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      beat = 0;
      ph   = 5;
      if (c < beats * BEAT) begin
        beat = c / BEAT;
        off  = c % BEAT;
        if (off < T_PH) ph = 0;
        else if (off == T_PH) ph = 1;
        else if (off <= 2 * T_PH) ph = 2;
        else ph = 3;
      end else if (c < len) begin
        ph = 4;
      end
      a = 8'(int'(addr) + beat);
      exp_str = {!(ph == 0 || ph == 2), !(ph == 0 || (ph == 2 && !rw)), !(ph == 2 && rw), ph != 0};
      exp_bus = 8'hFF;
      if (ph == 0 || ph == 1) exp_bus = a;
      else if ((ph == 2 || ph == 3) && !rw) exp_bus = wdata;
      else if (ph == 2 && rw) exp_bus = chip_mem[a];
      exp_rv = (ph == 3) && rw;
      if (exp_rv) last_rdata = chip_mem[a];
      exp_st = {c < len, c == len, exp_rv};

      n_checks++;
      if ({CS, WR, RD, AD} !== exp_str) begin
        n_fail++;
        $display("FAIL %s cyc %0d strobes CS/WR/RD/AD=%b required %b", tag, c, {CS, WR, RD, AD}, exp_str);
      end
      n_checks++;
      if (dato_rtc !== exp_bus) begin
        n_fail++;
        $display("FAIL %s cyc %0d bus=%h required %h", tag, c, dato_rtc, exp_bus);
      end
      n_checks++;
      if ({bus_if.busy, bus_if.done, bus_if.rd_valid} !== exp_st) begin
        n_fail++;
        $display("FAIL %s cyc %0d busy/done/rd_valid=%b required %b", tag, c,
                 {bus_if.busy, bus_if.done, bus_if.rd_valid}, exp_st);
      end
      n_checks++;
      if (bus_if.rdata !== last_rdata) begin
        n_fail++;
        $display("FAIL %s cyc %0d rdata=%h required %h", tag, c, bus_if.rdata, last_rdata);
      end

      if (hold_req && c < len) begin
        bus_if.rw    = 1'($urandom);
        bus_if.addr  = 8'($urandom);
        bus_if.wdata = 8'($urandom);
`ifdef RTC_BURST_EN
        bus_if.burst_len = 4'($urandom);
`endif
      end else if (!hold_req) begin
        bus_if.req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({CS, WR, RD, AD} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset strobes=%b required 1111", {CS, WR, RD, AD});
    end
    n_checks++;
    if (dato_rtc !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset bus=%h required released (ff)", dato_rtc);
    end
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.rd_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset busy/done/rd_valid=%b required 000", {bus_if.busy, bus_if.done, bus_if.rd_valid});
    end
    n_checks++;
    if (bus_if.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset rdata=%h required 00", bus_if.rdata);
    end
    n_checks++;
    if (clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset clk_out=%b required 0", clk_out);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_clk_out;
    int n;
    for (n = 1; n <= 3 * CLK_DIV; n++) begin
      @(posedge clk);
      #1;
      if (clk_out === 1'b1) break;
    end
    n_checks++;
    if (n != CLK_DIV) begin
      n_fail++;
      $display("FAIL clk_out_rise after %0d edges required %0d", n, CLK_DIV);
    end
    for (n = 1; n <= 3 * CLK_DIV; n++) begin
      @(posedge clk);
      #1;
      if (clk_out === 1'b0) break;
    end
    n_checks++;
    if (n != CLK_DIV) begin
      n_fail++;
      $display("FAIL clk_out_fall after %0d edges required %0d", n, CLK_DIV);
    end
    @(negedge clk);
  endtask

  task automatic test_write;
    do_txn(1'b0, 8'h21, 8'h5A, 0, 1'b0, "write");
  endtask

  task automatic test_read;
    chip_mem[8'h0A] = 8'hC3;
    do_txn(1'b1, 8'h0A, 8'h00, 0, 1'b0, "read");
  endtask

  task automatic test_back_to_back;
    chip_mem[8'h55] = 8'h3C;
    do_txn(1'b0, 8'h12, 8'hE7, 0, 1'b1, "b2b_w");
    do_txn(1'b1, 8'h55, 8'h00, 0, 1'b1, "b2b_r");
    do_txn(1'b0, 8'h56, 8'h81, 0, 1'b0, "b2b_w2");
  endtask

  task automatic test_clr_mid;
    bit bad;
    chip_mem[8'h33] = 8'hA5;
    do_txn(1'b1, 8'h33, 8'h00, 0, 1'b0, "pre_clr");
    bus_if.req   = 1'b1;
    bus_if.rw    = 1'b0;
    bus_if.addr  = 8'h40;
    bus_if.wdata = 8'h96;
    for (int c = 0; c <= T_PH + 2; c++) begin
      @(negedge clk);
      bus_if.req = 1'b0;
    end
    n_checks++;
    if ({WR, dato_rtc} !== {1'b0, 8'h96}) begin
      n_fail++;
      $display("FAIL clr_mid pre WR/bus=%b/%h required 0/96", WR, dato_rtc);
    end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({CS, WR, RD, AD, dato_rtc} !== {4'b1111, 8'hFF}) begin
      n_fail++;
      $display("FAIL clr_mid strobes/bus=%b/%h required 1111/ff", {CS, WR, RD, AD}, dato_rtc);
    end
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.rd_valid, bus_if.rdata} !== {3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL clr_mid busy/done/rd_valid/rdata=%b/%h required 000/00",
               {bus_if.busy, bus_if.done, bus_if.rd_valid}, bus_if.rdata);
    end
    @(negedge clk);
    clr = 1'b0;
    last_rdata = '0;
    bad = 1'b0;
    for (int c = 0; c < 2 * BEAT; c++) begin
      @(negedge clk);
      if (bus_if.done !== 1'b0 || bus_if.rd_valid !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL clr_mid_after stray busy/done/rd_valid seen=%b required 0", bad);
    end
    do_txn(1'b0, 8'h40, 8'h96, 0, 1'b0, "post_clr_w");
    do_txn(1'b1, 8'h33, 8'h00, 0, 1'b0, "post_clr_r");
  endtask

  task automatic test_random;
    logic rw;
    logic [7:0] a, d;
    int bl;
    bit hold;
    for (int i = 0; i < 24; i++) begin
      rw   = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      d    = 8'($urandom);
      bl   = BURST ? int'($urandom_range(0, 3)) : 0;
      hold = (i < 23) && ($urandom_range(0, 2) == 0);
      do_txn(rw, a, d, bl, hold, "rand");
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

`ifdef RTC_BURST_EN
  task automatic test_burst;
    do_txn(1'b1, 8'hFE, 8'h00, 3, 1'b0, "burst_rd");
    do_txn(1'b0, 8'h70, 8'h4B, 5, 1'b0, "burst_wr_single");
    do_txn(1'b1, 8'h10, 8'h00, 2, 1'b1, "burst_b2b");
    do_txn(1'b1, 8'hFF, 8'h00, 1, 1'b0, "burst_wrap");
  endtask
`endif

  initial begin
    clr          = 1'b1;
    bus_if.req   = 1'b0;
    bus_if.rw    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
`ifdef RTC_BURST_EN
    bus_if.burst_len = '0;
`endif
    for (int i = 0; i < 256; i++) chip_mem[i] = 8'($urandom);
    last_rdata = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_clk_out;
    test_write;
    test_read;
    test_back_to_back;
    test_clr_mid;
    test_random;
`ifdef RTC_BURST_EN
    test_burst;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
